// File: rtl/tpu_pkg.sv
// Shared types for the tpuv1 command sequencer: opcode encoding, controller states
// and default geometry.
package tpu_pkg;

  localparam int DIM_DEF   = 8;
  localparam int WIDTH_DEF = 32;
  localparam int STEPS_DEF = 22;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_WRITE_A = 3'd1,
    OP_WRITE_B = 3'd2,
    OP_WRITE_C = 3'd3,
    OP_MATMUL  = 3'd4,
    OP_READ_C  = 3'd5,
    OP_STEP    = 3'd6
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_STEP,
    S_READ_ISSUE,
    S_READ_CAP,
    S_READ_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/tpu_sequencer.sv
// Drives the tpuv1 opcode/idx/hl/vector ports: loads A and B from a row stream,
// runs the systolic steps and returns C as half-row beats over valid/ready.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEPS = STEPS_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DIM-1:0][WIDTH-1:0]       in_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DIM/2-1:0][WIDTH-1:0]     out_data,
  output logic                            out_last,
  output logic [2:0]                      tpu_opcode,
  output logic [3:0]                      tpu_idx,
  output logic                            tpu_hl,
  output logic [DIM/2-1:0][WIDTH-1:0]     tpu_v_high,
  output logic [DIM/2-1:0][WIDTH-1:0]     tpu_v_low,
  input  logic [DIM/2-1:0][WIDTH-1:0]     tpu_data_out
);

  localparam int RW = $clog2(DIM);
  localparam int SW = $clog2(STEPS + 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(DIM - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS);

  state_t          state;
  logic [RW-1:0]   row;
  logic [RW-1:0]   row_nxt;
  logic            hl;
  logic [SW-1:0]   step_cnt;
  logic            accept;

  assign row_nxt = row + 1'b1;
  assign accept  = in_valid && in_ready;

  // Outputs are loaded for the state being entered, so the readC opcode is on
  // the bus during READ_ISSUE and its result is present during READ_CAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row        <= '0;
      hl         <= 1'b0;
      step_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      tpu_opcode <= OP_NOP;
      tpu_idx    <= '0;
      tpu_hl     <= 1'b0;
      tpu_v_high <= '0;
      tpu_v_low  <= '0;
    end else begin
      tpu_opcode <= OP_NOP;
      tpu_hl     <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_A;
            row      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (accept) begin
            tpu_opcode <= (state == S_LOAD_A) ? OP_WRITE_A : OP_WRITE_B;
            tpu_idx    <= 4'(row);
            tpu_v_high <= in_row[DIM-1:DIM/2];
            tpu_v_low  <= in_row[DIM/2-1:0];
            row        <= row_nxt;
            if (row == ROW_LAST) begin
              row <= '0;
              if (state == S_LOAD_A) begin
                state <= S_LOAD_B;
              end else begin
                state    <= S_STEP;
                in_ready <= 1'b0;
                step_cnt <= '0;
              end
            end
          end
        end
        S_STEP: begin
          if (step_cnt == STEP_LAST) begin
            tpu_opcode <= OP_READ_C;
            tpu_idx    <= '0;
            tpu_hl     <= 1'b1;
            row        <= '0;
            hl         <= 1'b1;
            state      <= S_READ_ISSUE;
          end else begin
            tpu_opcode <= OP_STEP;
            step_cnt   <= step_cnt + 1'b1;
          end
        end
        S_READ_ISSUE: begin
          state <= S_READ_CAP;
        end
        S_READ_CAP: begin
          out_data  <= tpu_data_out;
          out_valid <= 1'b1;
          out_last  <= (row == ROW_LAST) && !hl;
          state     <= S_READ_OUT;
        end
        S_READ_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (hl) begin
              hl         <= 1'b0;
              tpu_opcode <= OP_READ_C;
              tpu_idx    <= 4'(row);
              tpu_hl     <= 1'b0;
              state      <= S_READ_ISSUE;
            end else if (row != ROW_LAST) begin
              row        <= row_nxt;
              hl         <= 1'b1;
              tpu_opcode <= OP_READ_C;
              tpu_idx    <= 4'(row_nxt);
              tpu_hl     <= 1'b1;
              state      <= S_READ_ISSUE;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer with a small integer tpuv1 model on the
// command port; expected C beats come from closed-form A/B patterns.
module tb_tpu_sequencer;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0][31:0]      in_row;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0][31:0]      out_data;
  logic                  out_last;
  logic [2:0]            tpu_opcode;
  logic [3:0]            tpu_idx;
  logic                  tpu_hl;
  logic [3:0][31:0]      tpu_v_high;
  logic [3:0][31:0]      tpu_v_low;
  logic [3:0][31:0]      tpu_data_out;

  tpu_sequencer #(.DIM(8), .WIDTH(32), .STEPS(22)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .tpu_opcode(tpu_opcode), .tpu_idx(tpu_idx), .tpu_hl(tpu_hl),
    .tpu_v_high(tpu_v_high), .tpu_v_low(tpu_v_low), .tpu_data_out(tpu_data_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // tpuv1 model: stores A/B rows, answers readC one cycle later, and flags any
  // opcode sequence that breaks the expected command order.
  int       ma[8][8];
  int       mb[8][8];
  int       n_wa, n_wb, n_st, n_rd, n_gap;
  bit [2:0] prev;
  bit       seq_bad;
  int       run_id = 0;
  int       seen_id = 0;
  int       cyc = 0;

  function automatic int cval(int i, int j);
    int s = 0;
    for (int k = 0; k < 8; k++) s += ma[i][k] * mb[k][j];
    return s;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tpu_data_out <= {4{32'hDEADBEEF}};
    if (!rst_n || run_id != seen_id) begin
      seen_id <= run_id;
      prev    <= 3'd0;
      n_wa    <= 0;
      n_wb    <= 0;
      n_st    <= 0;
      n_rd    <= 0;
      n_gap   <= 0;
    end else begin
      prev <= tpu_opcode;
      if (prev == 3'd5 && tpu_opcode != 3'd0) seq_bad <= 1'b1;
      if (prev == 3'd6 && tpu_opcode != 3'd6 && n_st != 22) seq_bad <= 1'b1;
      if (tpu_opcode == 3'd0 && (n_wa + n_wb) > 0 && (n_wa + n_wb) < 16) n_gap <= n_gap + 1;
      case (tpu_opcode)
        3'd0: ;
        3'd1: begin
          if (int'(tpu_idx) != n_wa) seq_bad <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            ma[tpu_idx[2:0]][k+4] <= int'(tpu_v_high[k]);
            ma[tpu_idx[2:0]][k]   <= int'(tpu_v_low[k]);
          end
          n_wa <= n_wa + 1;
        end
        3'd2: begin
          if (int'(tpu_idx) != n_wb || n_wa != 8) seq_bad <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            mb[tpu_idx[2:0]][k+4] <= int'(tpu_v_high[k]);
            mb[tpu_idx[2:0]][k]   <= int'(tpu_v_low[k]);
          end
          n_wb <= n_wb + 1;
        end
        3'd6: begin
          if (prev != 3'd6 && prev != 3'd2) seq_bad <= 1'b1;
          n_st <= n_st + 1;
        end
        3'd5: begin
          if (n_st != 22 || int'(tpu_idx) != n_rd / 2 || tpu_hl != (n_rd % 2 == 0)) seq_bad <= 1'b1;
          for (int k = 0; k < 4; k++)
            tpu_data_out[k] <= 32'(cval(int'(tpu_idx[2:0]), tpu_hl ? k + 4 : k));
          n_rd <= n_rd + 1;
        end
        default: seq_bad <= 1'b1;
      endcase
    end
  end

  int done_cnt = 0;
  int t_done = 0;
  int t0 = 0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      t_done   <= cyc;
    end
  end

  function automatic logic [7:0][31:0] mkrow(int r, bit perm, int boff);
    logic [7:0][31:0] v;
    for (int j = 0; j < 8; j++) begin
      if (r < 8) v[j] = (j == (perm ? 7 - r : r)) ? 32'd1 : 32'd0;
      else       v[j] = 32'(boff + 8 * (r - 8) + j);
    end
    return v;
  endfunction

  function automatic logic [3:0][31:0] exp_beat(int b, bit perm, int boff);
    logic [3:0][31:0] v;
    int i   = b / 2;
    int src = perm ? 7 - i : i;
    for (int k = 0; k < 4; k++)
      v[k] = 32'(boff + 8 * src + ((b % 2 == 0) ? k + 4 : k));
    return v;
  endfunction

  task automatic check_reset(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_last"}, out_last, 0);
    chk({pfx, "_tpu_hl"}, tpu_hl, 0);
    chk({pfx, "_opcode"}, tpu_opcode, 0);
    chk({pfx, "_idx"}, tpu_idx, 0);
    chk({pfx, "_v_high"}, tpu_v_high, 0);
    chk({pfx, "_v_low"}, tpu_v_low, 0);
    chk({pfx, "_out_data"}, out_data, 0);
  endtask

  // Called with start already driven high for the cycle that samples it.
  task automatic feed(input bit perm, input bit gap, input bit poke, input int boff);
    int r = 0, tmo = 0;
    bit tog = 0, first = 1;
    while (r < 16 && tmo < 200) begin
      @(negedge clk); tmo++;
      start = 0;
      if (first) begin
        chk("busy_cycle1", busy, 1);
        chk("in_ready_cycle1", in_ready, 1);
        first = 0;
      end
      if (poke && r == 10) start = 1;
      if (gap && tog) begin
        in_valid = 0;
        tog = 0;
      end else begin
        in_valid = 1;
        in_row = mkrow(r, perm, boff);
        if (in_ready) begin
          r++;
          tog = 1;
        end
      end
    end
    if (r < 16) chk("feed_timeout", r, 16);
    @(negedge clk);
    in_valid = 0;
    start = 0;
    chk("in_ready_step", in_ready, 0);
    chk("busy_step", busy, 1);
  endtask

  task automatic collect(input bit perm, input bit stall, input bit poke, input int boff);
    int b = 0, tmo = 0, rd0;
    logic [3:0][31:0] snap;
    bit steady;
    out_ready = !stall;
    while (b < 16 && tmo < 1500) begin
      @(negedge clk); tmo++;
      if (out_valid) begin
        if (stall) begin
          snap = out_data;
          rd0 = n_rd;
          steady = 1;
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            start = (poke && b == 3 && s == 0);
            if (!out_valid || out_data !== snap) steady = 0;
          end
          start = 0;
          chk($sformatf("beat%0d_stall_hold", b), steady, 1);
          chk($sformatf("beat%0d_stall_readc", b), n_rd, rd0);
          out_ready = 1;
        end
        chk($sformatf("beat%0d_data", b), out_data, exp_beat(b, perm, boff));
        chk($sformatf("beat%0d_last", b), out_last, (b == 15));
        b++;
        if (stall) begin
          @(negedge clk);
          out_ready = 0;
        end
      end
    end
    if (b < 16) chk("collect_timeout", b, 16);
  endtask

  task automatic run(input bit perm, input bit gap, input bit stall, input bit poke,
                     input int boff, input int exp_lat);
    int d0, tmo = 0;
    @(negedge clk);
    run_id++;
    @(negedge clk);
    d0 = done_cnt;
    start = 1;
    t0 = cyc;
    feed(perm, gap, poke, boff);
    collect(perm, stall, poke, boff);
    while (done_cnt == d0 && tmo < 20) begin
      @(negedge clk); tmo++;
    end
    repeat (3) @(negedge clk);
    out_ready = 0;
    chk("done_once", done_cnt - d0, 1);
    chk("latency", t_done - t0, exp_lat);
    chk("busy_after", busy, 0);
    chk("n_writeA", n_wa, 8);
    chk("n_writeB", n_wb, 8);
    chk("n_steps", n_st, 22);
    chk("n_readC", n_rd, 16);
    chk("n_load_gaps", n_gap, gap ? 15 : 0);
    chk("seq_order", seq_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int d0, tmo;
    rst_n = 0; start = 0; in_valid = 0; in_row = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1;

    // in_valid while idle must not be accepted or issue writes
    in_valid = 1;
    in_row = mkrow(9, 0, 77);
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_opcode", tpu_opcode, 0);
    chk("idle_busy", busy, 0);
    in_valid = 0;

    run(0, 0, 0, 0, 1000, 88);
    run(1, 1, 0, 0, 2000, 103);
    run(0, 0, 1, 1, 3000, 168);

    // abort during STEP after the 10th systolic_step
    @(negedge clk);
    run_id++;
    @(negedge clk);
    d0 = done_cnt;
    start = 1;
    t0 = cyc;
    feed(0, 0, 0, 4000);
    tmo = 0;
    while (n_st < 10 && tmo < 100) begin
      @(negedge clk); tmo++;
    end
    chk("step10_reached", n_st, 10);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check_reset("abort");
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_valid", out_valid, 0);

    run(1, 0, 0, 0, 5000, 88);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
